// File: rtl/reset_sequencer_if.sv
// Reset-distribution bundle between the PLL wrapper and the reset_sequencer.
// The master side consumes pll_reset and drives the staged resets.
interface reset_sequencer_if;
    logic       pll_reset;
    logic       rst_core;
    logic       rst_periph;
    logic       ready;
    logic [7:0] lock_losses;

    modport master (
        input  pll_reset,
        output rst_core,
        output rst_periph,
        output ready,
        output lock_losses
    );

    modport slave (
        output pll_reset,
        input  rst_core,
        input  rst_periph,
        input  ready,
        input  lock_losses
    );
endinterface

// File: rtl/reset_sequencer.sv
// Synchronises the raw PLL reset, filters lock, holds, then releases core and peripheral resets in two stages.
// Optional lock-loss counter is built when RESET_SEQ_LOSS_COUNT_EN is defined; otherwise lock_losses reads 0.
module reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8,
    parameter int HOLD_CYCLES   = 1024,
    parameter int STAGE_GAP     = 16
) (
    input  logic               clock,
    input  logic               reset,
    reset_sequencer_if.master  seq
);

    localparam int MAX_FH    = (FILTER_CYCLES > HOLD_CYCLES) ? FILTER_CYCLES : HOLD_CYCLES;
    localparam int MAX_COUNT = (MAX_FH > STAGE_GAP) ? MAX_FH : STAGE_GAP;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("reset_sequencer: FILTER_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        STAGE     = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Synchroniser presets to "unlocked" so a fresh reset always re-runs the full filter.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;
    logic lock_bad;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], seq.pll_reset};
        end
    end

    assign lock_bad = sync_reg[SYNC_STAGES-1];

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             rst_core_reg;
    logic             rst_periph_reg;
    logic             ready_reg;

    // Lock loss outranks a terminal count, so a drop on the final STAGE cycle never lets rst_periph glitch low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= WAIT_LOCK;
            count_reg      <= '0;
            rst_core_reg   <= 1'b1;
            rst_periph_reg <= 1'b1;
            ready_reg      <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_LOCK: begin
                    rst_core_reg   <= 1'b1;
                    rst_periph_reg <= 1'b1;
                    ready_reg      <= 1'b0;
                    if (lock_bad) begin
                        count_reg <= '0;
                    end else if (count_reg == FILTER_LAST) begin
                        state_reg <= HOLD;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (lock_bad) begin
                        state_reg <= WAIT_LOCK;
                        count_reg <= '0;
                    end else if (count_reg == HOLD_LAST) begin
                        state_reg    <= STAGE;
                        count_reg    <= '0;
                        rst_core_reg <= 1'b0;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                STAGE: begin
                    if (lock_bad) begin
                        state_reg    <= WAIT_LOCK;
                        count_reg    <= '0;
                        rst_core_reg <= 1'b1;
                    end else if (count_reg == GAP_LAST) begin
                        state_reg      <= RUN;
                        count_reg      <= '0;
                        rst_periph_reg <= 1'b0;
                        ready_reg      <= 1'b1;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                RUN: begin
                    if (lock_bad) begin
                        state_reg      <= WAIT_LOCK;
                        count_reg      <= '0;
                        rst_core_reg   <= 1'b1;
                        rst_periph_reg <= 1'b1;
                        ready_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= WAIT_LOCK;
                    count_reg      <= '0;
                    rst_core_reg   <= 1'b1;
                    rst_periph_reg <= 1'b1;
                    ready_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign seq.rst_core   = rst_core_reg;
    assign seq.rst_periph = rst_periph_reg;
    assign seq.ready      = ready_reg;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    logic       lock_lost;
    logic [7:0] loss_count_reg;

    // Only drops seen after the filter has passed count as losses.
    assign lock_lost = lock_bad && (state_reg != WAIT_LOCK);

    always_ff @(posedge clock) begin
        if (reset) begin
            loss_count_reg <= 8'd0;
        end else if (lock_lost && (loss_count_reg != 8'hFF)) begin
            loss_count_reg <= loss_count_reg + 8'd1;
        end
    end

    assign seq.lock_losses = loss_count_reg;
`else
    assign seq.lock_losses = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, lock glitches, losses in RUN/STAGE, mid-sequence reset, saturation.
module tb_reset_sequencer;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   exp_loss;

    reset_sequencer_if seq_if ();

    reset_sequencer #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (8),
        .HOLD_CYCLES   (16),
        .STAGE_GAP     (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .seq   (seq_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_pll(input logic v);
        @(negedge clock);
        seq_if.pll_reset = v;
    endtask

    task automatic bump_loss();
        if (LOSS_EN) exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
        else exp_loss = 0;
    endtask

    task automatic test_reset();
        seq_if.pll_reset = 1'b0;
        reset = 1'b1;
        exp_loss = 0;
        edges(3);
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL reset_core: rst_core=%b expected 1", seq_if.rst_core); end
        checks++; if (seq_if.rst_periph !== 1'b1) begin errors++; $display("FAIL reset_periph: rst_periph=%b expected 1", seq_if.rst_periph); end
        checks++; if (seq_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: ready=%b expected 0", seq_if.ready); end
        checks++; if (seq_if.lock_losses !== 8'd0) begin errors++; $display("FAIL reset_losses: lock_losses=%0d expected 0", seq_if.lock_losses); end
        @(negedge clock);
        reset = 1'b0;
        edges(25);
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL pu_core_edge25: rst_core=%b expected 1", seq_if.rst_core); end
        edges(1);
        checks++; if (seq_if.rst_core !== 1'b0) begin errors++; $display("FAIL pu_core_edge26: rst_core=%b expected 0", seq_if.rst_core); end
        checks++; if (seq_if.rst_periph !== 1'b1) begin errors++; $display("FAIL pu_periph_edge26: rst_periph=%b expected 1", seq_if.rst_periph); end
        edges(3);
        checks++; if (seq_if.ready !== 1'b0) begin errors++; $display("FAIL pu_ready_edge29: ready=%b expected 0", seq_if.ready); end
        edges(1);
        checks++; if (seq_if.rst_periph !== 1'b0) begin errors++; $display("FAIL pu_periph_edge30: rst_periph=%b expected 0", seq_if.rst_periph); end
        checks++; if (seq_if.ready !== 1'b1) begin errors++; $display("FAIL pu_ready_edge30: ready=%b expected 1", seq_if.ready); end
        checks++; if (seq_if.lock_losses !== 8'(exp_loss)) begin errors++; $display("FAIL pu_losses: lock_losses=%0d expected %0d", seq_if.lock_losses, exp_loss); end
        $display("[%0t] power_up: core=%b periph=%b ready=%b losses=%0d", $time, seq_if.rst_core, seq_if.rst_periph, seq_if.ready, seq_if.lock_losses);
    endtask

    task automatic test_loss_run();
        drive_pll(1'b1);
        edges(2);
        checks++; if (seq_if.ready !== 1'b1) begin errors++; $display("FAIL run_loss_edge2: ready=%b expected 1", seq_if.ready); end
        edges(1);
        bump_loss();
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL run_loss_core: rst_core=%b expected 1", seq_if.rst_core); end
        checks++; if (seq_if.rst_periph !== 1'b1) begin errors++; $display("FAIL run_loss_periph: rst_periph=%b expected 1", seq_if.rst_periph); end
        checks++; if (seq_if.ready !== 1'b0) begin errors++; $display("FAIL run_loss_ready: ready=%b expected 0", seq_if.ready); end
        checks++; if (seq_if.lock_losses !== 8'(exp_loss)) begin errors++; $display("FAIL run_loss_count: lock_losses=%0d expected %0d", seq_if.lock_losses, exp_loss); end
        edges(7);
        drive_pll(1'b0);
        edges(25);
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL run_rel_core25: rst_core=%b expected 1", seq_if.rst_core); end
        edges(1);
        checks++; if (seq_if.rst_core !== 1'b0) begin errors++; $display("FAIL run_rel_core26: rst_core=%b expected 0", seq_if.rst_core); end
        edges(4);
        checks++; if (seq_if.ready !== 1'b1) begin errors++; $display("FAIL run_rel_ready30: ready=%b expected 1", seq_if.ready); end
        $display("[%0t] loss_in_run: losses=%0d ready=%b", $time, seq_if.lock_losses, seq_if.ready);
    endtask

    task automatic test_loss_stage();
        drive_pll(1'b1);
        edges(3);
        bump_loss();
        edges(2);
        drive_pll(1'b0);
        edges(26);
        checks++; if (seq_if.rst_core !== 1'b0) begin errors++; $display("FAIL stage_core_low: rst_core=%b expected 0", seq_if.rst_core); end
        edges(1);
        drive_pll(1'b1);
        for (int k = 1; k <= 3; k++) begin
            edges(1);
            checks++; if (seq_if.rst_periph !== 1'b1) begin errors++; $display("FAIL stage_periph_k%0d: rst_periph=%b expected 1", k, seq_if.rst_periph); end
            checks++; if (seq_if.rst_core !== (k == 3)) begin errors++; $display("FAIL stage_core_k%0d: rst_core=%b expected %b", k, seq_if.rst_core, (k == 3)); end
        end
        bump_loss();
        checks++; if (seq_if.ready !== 1'b0) begin errors++; $display("FAIL stage_ready: ready=%b expected 0", seq_if.ready); end
        checks++; if (seq_if.lock_losses !== 8'(exp_loss)) begin errors++; $display("FAIL stage_loss_count: lock_losses=%0d expected %0d", seq_if.lock_losses, exp_loss); end
        $display("[%0t] loss_in_stage: core=%b periph=%b losses=%0d", $time, seq_if.rst_core, seq_if.rst_periph, seq_if.lock_losses);
    endtask

    task automatic test_mid_reset();
        drive_pll(1'b0);
        edges(14);
        checks++; if (seq_if.lock_losses !== 8'(exp_loss)) begin errors++; $display("FAIL mid_pre_losses: lock_losses=%0d expected %0d", seq_if.lock_losses, exp_loss); end
        @(negedge clock);
        reset = 1'b1;
        edges(1);
        exp_loss = 0;
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL mid_core: rst_core=%b expected 1", seq_if.rst_core); end
        checks++; if (seq_if.rst_periph !== 1'b1) begin errors++; $display("FAIL mid_periph: rst_periph=%b expected 1", seq_if.rst_periph); end
        checks++; if (seq_if.ready !== 1'b0) begin errors++; $display("FAIL mid_ready: ready=%b expected 0", seq_if.ready); end
        checks++; if (seq_if.lock_losses !== 8'd0) begin errors++; $display("FAIL mid_losses: lock_losses=%0d expected 0", seq_if.lock_losses); end
        @(negedge clock);
        reset = 1'b0;
        edges(25);
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL mid_core25: rst_core=%b expected 1", seq_if.rst_core); end
        edges(1);
        checks++; if (seq_if.rst_core !== 1'b0) begin errors++; $display("FAIL mid_core26: rst_core=%b expected 0", seq_if.rst_core); end
        edges(3);
        checks++; if (seq_if.rst_periph !== 1'b1) begin errors++; $display("FAIL mid_periph29: rst_periph=%b expected 1", seq_if.rst_periph); end
        edges(1);
        checks++; if (seq_if.rst_periph !== 1'b0) begin errors++; $display("FAIL mid_periph30: rst_periph=%b expected 0", seq_if.rst_periph); end
        checks++; if (seq_if.ready !== 1'b1) begin errors++; $display("FAIL mid_ready30: ready=%b expected 1", seq_if.ready); end
        $display("[%0t] mid_sequence_reset: losses=%0d ready=%b", $time, seq_if.lock_losses, seq_if.ready);
    endtask

    task automatic test_glitch();
        drive_pll(1'b1);
        reset = 1'b1;
        edges(2);
        exp_loss = 0;
        checks++; if (seq_if.lock_losses !== 8'd0) begin errors++; $display("FAIL glitch_pre_losses: lock_losses=%0d expected 0", seq_if.lock_losses); end
        @(negedge clock);
        reset = 1'b0;
        edges(3);
        drive_pll(1'b0);
        edges(4);
        drive_pll(1'b1);
        edges(1);
        drive_pll(1'b0);
        edges(25);
        checks++; if (seq_if.rst_core !== 1'b1) begin errors++; $display("FAIL glitch_core25: rst_core=%b expected 1", seq_if.rst_core); end
        edges(1);
        checks++; if (seq_if.rst_core !== 1'b0) begin errors++; $display("FAIL glitch_core26: rst_core=%b expected 0", seq_if.rst_core); end
        checks++; if (seq_if.lock_losses !== 8'd0) begin errors++; $display("FAIL glitch_losses: lock_losses=%0d expected 0", seq_if.lock_losses); end
        edges(4);
        checks++; if (seq_if.ready !== 1'b1) begin errors++; $display("FAIL glitch_ready30: ready=%b expected 1", seq_if.ready); end
        $display("[%0t] glitchy_lock: core=%b ready=%b losses=%0d", $time, seq_if.rst_core, seq_if.ready, seq_if.lock_losses);
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 260; i++) begin
            drive_pll(1'b1);
            edges(3);
            bump_loss();
            checks++; if (seq_if.ready !== 1'b0) begin errors++; $display("FAIL sat_drop_%0d: ready=%b expected 0", i, seq_if.ready); end
            checks++; if (seq_if.lock_losses !== 8'(exp_loss)) begin errors++; $display("FAIL sat_count_%0d: lock_losses=%0d expected %0d", i, seq_if.lock_losses, exp_loss); end
            drive_pll(1'b0);
            edges(30);
            checks++; if (seq_if.ready !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d: ready=%b expected 1", i, seq_if.ready); end
            $display("[%0t] saturation loss %0d: losses=%0d", $time, i, seq_if.lock_losses);
        end
        checks++; if (seq_if.lock_losses !== (LOSS_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_final: lock_losses=%0d expected %0d", seq_if.lock_losses, LOSS_EN ? 255 : 0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_loss = 0;
        reset = 1'b1;
        seq_if.pll_reset = 1'b1;
        test_reset();
        test_loss_run();
        test_loss_stage();
        test_mid_reset();
        test_glitch();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
